// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side bus of the unified IF/MEM memory port arbiter.
// The arbiter uses the slave modport; requesters and the memory macro use master.
interface mem_port_arbiter_if #(
    parameter int N = 32
);
    logic         if_req;
    logic [N-1:0] if_addr;
    logic [N-1:0] if_rdata;
    logic         if_ack;
    logic         dm_req;
    logic         dm_we;
    logic [N-1:0] dm_addr;
    logic [N-1:0] dm_wdata;
    logic [N-1:0] dm_rdata;
    logic         dm_ack;
    logic         mem_en;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;
    logic         stall_if;
    logic         stall_mem;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store, one access at a time.
// Define ARB_RR_EN for round-robin arbitration; otherwise dm has fixed priority over if.
module mem_port_arbiter #(
    parameter int N       = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t       r_state;
    logic         r_gnt_dm;
    logic [3:0]   r_cnt;
    logic         r_mem_en;
    logic         r_mem_we;
    logic [N-1:0] r_mem_addr;
    logic [N-1:0] r_mem_wdata;
    logic [N-1:0] r_if_rdata;
    logic [N-1:0] r_dm_rdata;
    logic         r_if_ack;
    logic         r_dm_ack;
    logic         w_if_elig;
    logic         w_dm_elig;
    logic         w_pick_dm;
    logic         w_grant;

    // In DONE the requester being acked still holds req for this cycle; it must not win again.
    assign w_if_elig = bus.if_req & ~((r_state == DONE) & ~r_gnt_dm);
    assign w_dm_elig = bus.dm_req & ~((r_state == DONE) &  r_gnt_dm);
    assign w_grant   = ((r_state == IDLE) | (r_state == DONE)) & (w_if_elig | w_dm_elig);

`ifdef ARB_RR_EN
    logic r_last_dm;

    assign w_pick_dm = w_dm_elig & (~w_if_elig | ~r_last_dm);

    always_ff @(posedge clk) begin
        if (rst)
            r_last_dm <= 1'b0;
        else if (w_grant)
            r_last_dm <= w_pick_dm;
    end
`else
    assign w_pick_dm = w_dm_elig;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt_dm    <= 1'b0;
            r_cnt       <= 4'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
        end else begin
            r_mem_en <= 1'b0;
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_grant) begin
                        // The memory command registers double as the latched grant.
                        r_state    <= ISSUE;
                        r_gnt_dm   <= w_pick_dm;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= w_pick_dm & bus.dm_we;
                        r_mem_addr <= w_pick_dm ? bus.dm_addr : bus.if_addr;
                        if (w_pick_dm)
                            r_mem_wdata <= bus.dm_wdata;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= LAT;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= DONE;
                        if (r_gnt_dm) begin
                            r_dm_ack <= 1'b1;
                            if (!r_mem_we)
                                r_dm_rdata <= bus.mem_rdata;
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= bus.mem_rdata;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.if_ack    = r_if_ack;
    assign bus.dm_ack    = r_dm_ack;
    assign bus.stall_if  = bus.if_req & ~r_if_ack;
    assign bus.stall_mem = bus.dm_req & ~r_dm_ack;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single unified memory port between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipelined RISC core. It arbitrates, sequences one access at a time through a fixed-latency memory, and returns data and acknowledges to each requester. It drives the stall signals the IF_ID and later pipeline registers use to hold while an access is outstanding. It sits between `program_counter`/`IF_ID`/`EX_MEM` and the shared memory macro, replacing separate instruction and data memory ports.

## Interface
- N, 32, data and address width
- MEM_LAT, 2, memory read latency in cycles after the enable cycle; legal range 1..15
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- if_req  input  1  fetch request, level; held until if_ack
- if_addr  input  N  fetch address
- if_rdata  output  N  fetched instruction; valid while if_ack=1
- if_ack  output  1  one-cycle completion pulse for the fetch
- dm_req  input  1  data request, level; held until dm_ack
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  N  data address
- dm_wdata  input  N  store data
- dm_rdata  output  N  load data; valid while dm_ack=1
- dm_ack  output  1  one-cycle completion pulse for the data access
- mem_en  output  1  memory command strobe, one cycle per access
- mem_we  output  1  memory write enable, qualified by mem_en
- mem_addr  output  N  memory address
- mem_wdata  output  N  memory write data
- mem_rdata  input  N  memory read data, valid MEM_LAT cycles after the mem_en cycle
- stall_if  output  1  combinational: if_req & ~if_ack
- stall_mem  output  1  combinational: dm_req & ~dm_ack

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitrate. If any eligible request is present, go to ISSUE. Latch the winner's id, addr, we and wdata. An IF winner forces we=0.
- ISSUE: drive mem_en=1 with the latched mem_we, mem_addr and mem_wdata for exactly one cycle. Load the counter with MEM_LAT, then go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter reaches 1, capture mem_rdata into the winner's rdata register, but only for reads. Then go to DONE.
- DONE: pulse the winner's ack for one cycle. Arbitrate again in the same cycle, with the just-served requester excluded. Go to ISSUE if the other requester is waiting, else go to IDLE.
- Stores: same schedule as loads. dm_ack is pulsed and dm_rdata is left unchanged.
- Fixed priority (default): dm beats if on conflict, because it belongs to the older instruction.
- Address and data are latched at grant. Requester input changes after grant are ignored until ack.
- mem_en, mem_we, mem_addr and mem_wdata are registered. mem_we, mem_addr and mem_wdata hold their last value outside ISSUE. mem_en=0 outside ISSUE.
- Reset values: state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, counter=0, last_grant=IF.

## Timing
- A request seen in IDLE at cycle T produces: ISSUE at T+1, WAIT at T+2..T+1+MEM_LAT, and ack at T+2+MEM_LAT. Request-to-ack latency is MEM_LAT+2.
- Back-to-back with both requesting: the second ISSUE follows the first ack with no idle cycle. Period is MEM_LAT+2 per access.
- A requester that keeps req high in the cycle after its ack is treated as a new request.
- Simultaneous if_req and dm_req in IDLE: the grant follows the priority rule, and the loser's stall stays asserted.
- rst mid-access, in any state: return to IDLE next cycle, drop the outstanding access with no ack, and ignore later mem_rdata.
- MEM_LAT=1: WAIT lasts one cycle, and the capture happens in that cycle.

## Configuration
- ARB_RR_EN defined: round-robin arbitration. On conflict, grant the requester opposite to last_grant. last_grant updates at each grant. Since the reset value is IF, the first conflict goes to dm.
- ARB_RR_EN undefined: fixed dm-over-if priority. last_grant is not implemented. A continuous dm_req may starve fetch, which is acceptable because the pipeline limits MEM-stage requests.

## Test plan
- Single fetch: rst for 2 cycles, then if_req=1 with if_addr=0x40 at T and mem_rdata=0x00500093 returned on schedule (MEM_LAT=2) -> mem_en=1 and mem_addr=0x40 at T+1; if_ack=1 and if_rdata=0x00500093 at T+4; stall_if=1 from T to T+3.
- Store: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> mem_en=1, mem_we=1 with that addr/data at T+1; dm_ack at T+4; dm_rdata unchanged.
- Conflict: if_req and dm_req both asserted at T -> dm served first (ack at T+4); IF ISSUE at T+5 and if_ack at T+8. The same result is required with ARB_RR_EN at the first conflict.
- Round-robin (ARB_RR_EN): both requests held continuously -> grants alternate dm, if, dm, if, with acks at T+4, T+8, T+12, T+16.
- Reset mid-access: rst=1 in the WAIT cycle of a load -> no dm_ack; all outputs at reset values the next cycle; a fresh request afterwards completes in MEM_LAT+2 cycles.
